// File: rtl/program_loader_if.sv
// Boot loader bus bundle: UART byte stream in, acknowledge byte out,
// instruction-memory write port and core release signals.
interface program_loader_if #(
  parameter int ADDR_W = 5
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rstn;
  logic              loaded;

  // master: the loader itself; slave: UART, instruction memory and core side
  modport master (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, imem_we, imem_addr, imem_wdata, core_rstn, loaded
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, imem_we, imem_addr, imem_wdata, core_rstn, loaded
  );
endinterface

// File: rtl/program_loader.sv
// Boot sequencer: holds the core in reset, loads a length-prefixed little-endian
// program into instruction memory, sends an acknowledge byte, then releases the core.
module program_loader #(
  parameter int          ADDR_W   = 5,
  parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              rst,
  program_loader_if.master  bus
);

  typedef enum logic [1:0] {HDR, LOAD, ACK, RUN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       n_q, n_d;
  logic [31:0]       word_cnt_q, word_cnt_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              core_rstn_q, core_rstn_d;
  logic              loaded_q, loaded_d;

  logic [31:0]       word_in;
  logic              word_done;

  always_comb begin
    // Bytes shift in from the top so the first byte ends up in [7:0].
    word_in      = {bus.rx_data, shift_q[31:8]};
    word_done    = bus.rx_valid && (byte_cnt_q == 2'd3);

    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    n_d          = n_q;
    word_cnt_d   = word_cnt_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_rstn_d  = core_rstn_q;
    loaded_d     = loaded_q;

    case (state_q)
      HDR: begin
        if (bus.rx_valid) begin
          shift_d    = word_in;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (word_done) begin
            n_d = word_in;
            if (word_in == 32'd0) begin
              // Empty program: acknowledge immediately.
              state_d    = ACK;
              tx_valid_d = 1'b1;
              tx_data_d  = ACK_BYTE;
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      LOAD: begin
        if (bus.rx_valid) begin
          shift_d    = word_in;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (word_done) begin
            word_cnt_d   = word_cnt_q + 32'd1;
            imem_addr_d  = word_cnt_q[ADDR_W-1:0];
            imem_wdata_d = word_in;
            // Words beyond memory depth are counted but never written.
            imem_we_d    = (word_cnt_q[31:ADDR_W] == '0);
            if (word_cnt_q + 32'd1 == n_q) begin
              state_d = ACK;
            end
          end
        end
      end
      ACK: begin
        if (tx_valid_q && bus.tx_ready) begin
          state_d     = RUN;
          tx_valid_d  = 1'b0;
          tx_data_d   = 8'd0;
          core_rstn_d = 1'b1;
          loaded_d    = 1'b1;
        end else begin
          tx_valid_d = 1'b1;
          tx_data_d  = ACK_BYTE;
        end
      end
      RUN: begin
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HDR;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 32'd0;
      n_q          <= 32'd0;
      word_cnt_q   <= 32'd0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      core_rstn_q  <= 1'b0;
      loaded_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rstn_q  <= core_rstn_d;
      loaded_q     <= loaded_d;
    end
  end

  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.core_rstn  = core_rstn_q;
  assign bus.loaded     = loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a byte-history reference model checked
// every cycle, plus literal expectations for the directed load scenarios.
module tb_program_loader;
  localparam int         ADDR_W = 5;
  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [7:0] ACKB   = 8'hAA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();
  program_loader #(.ADDR_W(ADDR_W), .ACK_BYTE(ACKB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // ready driver: 0 = held low, 1 = held high, 2 = random
  int rdy_mode = 1;
  always @(negedge clk) begin
    if (rdy_mode == 0)      bus.tx_ready = 1'b0;
    else if (rdy_mode == 1) bus.tx_ready = 1'b1;
    else                    bus.tx_ready = 1'($urandom_range(0, 1));
  end

  // Reference model: derives everything from the bytes accepted since reset.
  logic [7:0]        m_bytes[$];
  logic [31:0]       m_n;
  bit                m_acking, m_released, m_in_reset;
  logic              m_txv = 1'b0, m_we = 1'b0, m_rstn = 1'b0;
  logic [7:0]        m_txd = 8'd0;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata, m_w;
  logic              c_rst, c_rxv, c_txr, prev_txv = 1'b0;
  logic [7:0]        c_rxd;
  int                nb, idx;

  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [31:0]       wr_data_log[$];
  int                ack_cnt = 0;

  always begin
    @(posedge clk);
    c_rst = rst; c_rxv = bus.rx_valid; c_rxd = bus.rx_data; c_txr = bus.tx_ready;
    if (!c_rst && prev_txv && c_txr) ack_cnt++;
    m_we = 1'b0; m_in_reset = 1'b0;
    if (c_rst) begin
      m_bytes.delete();
      m_acking = 0; m_released = 0; m_in_reset = 1;
      m_txv = 1'b0; m_txd = 8'd0; m_rstn = 1'b0;
    end else if (m_released) begin
    end else if (m_acking) begin
      if (m_txv && c_txr) begin
        m_released = 1; m_txv = 1'b0; m_rstn = 1'b1;
      end else begin
        m_txv = 1'b1; m_txd = ACKB;
      end
    end else if (c_rxv) begin
      m_bytes.push_back(c_rxd);
      nb = m_bytes.size();
      if (nb % 4 == 0) begin
        m_w = {m_bytes[nb-1], m_bytes[nb-2], m_bytes[nb-3], m_bytes[nb-4]};
        if (nb == 4) begin
          m_n = m_w;
          if (m_w == 32'd0) begin
            m_acking = 1; m_txv = 1'b1; m_txd = ACKB;
          end
        end else begin
          idx = nb / 4 - 2;
          if (idx < DEPTH) begin
            m_we = 1'b1; m_addr = idx[ADDR_W-1:0]; m_wdata = m_w;
          end
          if (32'(idx + 1) == m_n) m_acking = 1;
        end
      end
    end
    #1;
    chk("tx_valid", 32'(bus.tx_valid), 32'(m_txv));
    chk("core_rstn", 32'(bus.core_rstn), 32'(m_rstn));
    chk("loaded", 32'(bus.loaded), 32'(m_rstn));
    chk("imem_we", 32'(bus.imem_we), 32'(m_we));
    if (m_txv || m_in_reset) chk("tx_data", 32'(bus.tx_data), 32'(m_txd));
    if (m_we || m_in_reset) begin
      chk("imem_addr", 32'(bus.imem_addr), m_in_reset ? 32'd0 : 32'(m_addr));
      chk("imem_wdata", bus.imem_wdata, m_in_reset ? 32'd0 : m_wdata);
    end
    if (bus.imem_we === 1'b1) begin
      wr_addr_log.push_back(bus.imem_addr);
      wr_data_log.push_back(bus.imem_wdata);
    end
    prev_txv = bus.tx_valid;
  end

  // Stimulus tasks start and end just after a falling edge.
  task automatic apply_reset(input bit rx_during_rst);
    rst = 1'b1;
    bus.rx_valid = rx_during_rst;
    bus.rx_data  = 8'($urandom);
    @(negedge clk);
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    wr_addr_log.delete();
    wr_data_log.delete();
    ack_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic wait_release(input int limit);
    int k = 0;
    while (bus.loaded !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("release_timeout", 32'(bus.loaded), 32'd1);
  endtask

  logic [31:0] prog3[3];
  logic [31:0] words[$];
  int          n_rand, log_before;

  initial begin
    prog3[0] = 32'h00100093;
    prog3[1] = 32'h00100113;
    prog3[2] = 32'h00200213;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    apply_reset(1'b0);
    chk("reset_core_rstn", 32'(bus.core_rstn), 32'd0);
    chk("reset_tx_valid", 32'(bus.tx_valid), 32'd0);

    // Normal load with random byte gaps, then back-to-back bytes.
    for (int pass = 0; pass < 2; pass++) begin
      rdy_mode = 1;
      apply_reset(1'b0);
      send_word(32'd3, pass == 0 ? 2 : 0);
      for (int i = 0; i < 3; i++) send_word(prog3[i], pass == 0 ? 2 : 0);
      wait_release(50);
      chk("load3_nwrites", 32'(wr_addr_log.size()), 32'd3);
      for (int i = 0; i < 3 && i < wr_addr_log.size(); i++) begin
        chk("load3_addr", 32'(wr_addr_log[i]), 32'(i));
        chk("load3_data", wr_data_log[i], prog3[i]);
      end
      chk("load3_acks", 32'(ack_cnt), 32'd1);
    end

    // Empty program with the transmitter stalled for 10 cycles.
    rdy_mode = 0;
    apply_reset(1'b0);
    send_word(32'd0, 1);
    repeat (10) begin
      chk("stall_tx_valid", 32'(bus.tx_valid), 32'd1);
      chk("stall_tx_data", 32'(bus.tx_data), 32'hAA);
      chk("stall_core_rstn", 32'(bus.core_rstn), 32'd0);
      @(negedge clk);
    end
    rdy_mode = 1;
    wait_release(20);
    chk("empty_nwrites", 32'(wr_addr_log.size()), 32'd0);
    chk("empty_acks", 32'(ack_cnt), 32'd1);

    // Overflow: 34 words into a 32-word memory.
    rdy_mode = 2;
    apply_reset(1'b0);
    words.delete();
    for (int i = 0; i < 34; i++) words.push_back($urandom);
    send_word(32'd34, 1);
    foreach (words[i]) send_word(words[i], 1);
    wait_release(100);
    chk("ovf_nwrites", 32'(wr_addr_log.size()), 32'd32);
    for (int i = 0; i < 32 && i < wr_addr_log.size(); i++) begin
      chk("ovf_addr", 32'(wr_addr_log[i]), 32'(i));
      chk("ovf_data", wr_data_log[i], words[i]);
    end
    chk("ovf_acks", 32'(ack_cnt), 32'd1);

    // Reset in the middle of a word, with a byte strobe during reset.
    rdy_mode = 1;
    apply_reset(1'b0);
    send_word(32'd2, 0);
    send_byte(8'h77, 0);
    send_byte(8'h66, 0);
    apply_reset(1'b1);
    chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("midrst_imem_we", 32'(bus.imem_we), 32'd0);
    chk("midrst_wdata", bus.imem_wdata, 32'd0);
    send_word(32'd1, 1);
    send_word(32'h00000013, 1);
    wait_release(50);
    chk("midrst_nwrites", 32'(wr_addr_log.size()), 32'd1);
    if (wr_addr_log.size() > 0) begin
      chk("midrst_addr", 32'(wr_addr_log[0]), 32'd0);
      chk("midrst_data", wr_data_log[0], 32'h00000013);
    end

    // Bytes after release must have no effect.
    log_before = wr_addr_log.size();
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), $urandom_range(0, 1));
    repeat (3) @(negedge clk);
    chk("run_nwrites", 32'(wr_addr_log.size()), 32'(log_before));
    chk("run_acks", 32'(ack_cnt), 32'd1);
    chk("run_core_rstn", 32'(bus.core_rstn), 32'd1);
    chk("run_loaded", 32'(bus.loaded), 32'd1);
    chk("run_tx_valid", 32'(bus.tx_valid), 32'd0);

    // Random programs with random gaps and random transmitter readiness.
    for (int t = 0; t < 4; t++) begin
      rdy_mode = 2;
      apply_reset(1'($urandom_range(0, 1)));
      n_rand = $urandom_range(1, 8);
      words.delete();
      for (int i = 0; i < n_rand; i++) words.push_back($urandom);
      send_word(32'(n_rand), 3);
      foreach (words[i]) send_word(words[i], 3);
      wait_release(100);
      chk("rand_nwrites", 32'(wr_addr_log.size()), 32'(n_rand));
      for (int i = 0; i < n_rand && i < wr_addr_log.size(); i++) begin
        chk("rand_addr", 32'(wr_addr_log[i]), 32'(i));
        chk("rand_data", wr_data_log[i], words[i]);
      end
      chk("rand_acks", 32'(ack_cnt), 32'd1);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
